wb_select_unit: RTL

Parametrised write-back stage for the multi-cycle CPU, successor to the two-input memory/ALU write-back mux. Selects one of four result sources (ALU, memory, link address, immediate) and latches the operands at issue. For loads, it waits on a memory-valid handshake with a timeout, then aligns and sign/zero-extends byte and halfword data. It delivers a single registered register-file write pulse and sits between the datapath result registers and the register file write port.

---
 rtl/wb_select_unit_if.sv | 37 +++
 rtl/wb_select_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/wb_select_unit_if.sv
// Write-back stage bus: issue request, operand sources, memory read
// handshake and register-file write port.
//   master : datapath side (drives issue/operands/memory, observes results)
//   slave  : wb_select_unit side
interface wb_select_unit_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  logic              wb_start;
  logic [1:0]        wb_sel;
  logic [2:0]        ld_mode;
  logic [1:0]        addr_lo;
  logic [REG_AW-1:0] wb_rd;
  logic [WIDTH-1:0]  alu_data;
  logic [WIDTH-1:0]  link_data;
  logic [WIDTH-1:0]  imm_data;
  logic [WIDTH-1:0]  mem_data;
  logic              mem_valid;
  logic              reg_we;
  logic [REG_AW-1:0] reg_waddr;
  logic [WIDTH-1:0]  reg_wdata;
  logic              busy;
  logic              err_align;
  logic              err_timeout;

  modport master (
    output wb_start, wb_sel, ld_mode, addr_lo, wb_rd,
    output alu_data, link_data, imm_data, mem_data, mem_valid,
    input  reg_we, reg_waddr, reg_wdata, busy, err_align, err_timeout
  );

  modport slave (
    input  wb_start, wb_sel, ld_mode, addr_lo, wb_rd,
    input  alu_data, link_data, imm_data, mem_data, mem_valid,
    output reg_we, reg_waddr, reg_wdata, busy, err_align, err_timeout
  );
endinterface

// File: rtl/wb_select_unit.sv
// wb_select_unit: write-back stage of the multi-cycle CPU.
// Selects ALU / MEM / LINK / IMM result, handles load alignment,
// sign/zero extension and a memory-valid wait with timeout, and issues a
// single registered register-file write pulse.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : wb_select_unit_if.slave (issue, operands, memory, write port,
//            busy and error pulses)
module wb_select_unit #(
  parameter int WIDTH       = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_select_unit_if.slave bus
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WAIT_MEM} state_e;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LH  = 3'd1,
    LD_LHU = 3'd2,
    LD_LB  = 3'd3,
    LD_LBU = 3'd4
  } ld_mode_e;

  state_e            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [2:0]        mode_q, mode_d;
  logic [1:0]        alo_q, alo_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              we_q, we_d;
  logic [REG_AW-1:0] waddr_q, waddr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              ealign_q, ealign_d;
  logic              etmo_q, etmo_d;
  logic [WIDTH-1:0]  operand;

  function automatic logic misaligned(logic [2:0] mode, logic [1:0] alo);
    case (mode)
      LD_LH, LD_LHU: misaligned = alo[0];
      LD_LB, LD_LBU: misaligned = 1'b0;
      default:       misaligned = (alo != 2'd0);
    endcase
  endfunction

  // Shifting by 8*alo selects the byte lane; for halfwords alo[0] is known
  // to be 0 here, so the same shift equals 16*alo[1]. For LW alo is 0.
  function automatic logic [WIDTH-1:0] extract(logic [2:0] mode, logic [1:0] alo,
                                               logic [WIDTH-1:0] data);
    logic [31:0] lane;
    lane = data[31:0] >> {alo, 3'b000};
    case (mode)
      LD_LB:   extract = {{(WIDTH-8){lane[7]}}, lane[7:0]};
      LD_LBU:  extract = {{(WIDTH-8){1'b0}}, lane[7:0]};
      LD_LH:   extract = {{(WIDTH-16){lane[15]}}, lane[15:0]};
      LD_LHU:  extract = {{(WIDTH-16){1'b0}}, lane[15:0]};
      default: extract = WIDTH'(lane);
    endcase
  endfunction

  always_comb begin
    case (bus.wb_sel)
      2'd2:    operand = bus.link_data;
      2'd3:    operand = bus.imm_data;
      default: operand = bus.alu_data;
    endcase
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    mode_d   = mode_q;
    alo_d    = alo_q;
    rd_d     = rd_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    ealign_d = 1'b0;
    etmo_d   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.wb_start) begin
          mode_d = bus.ld_mode;
          alo_d  = bus.addr_lo;
          rd_d   = bus.wb_rd;
          if (bus.wb_sel != 2'd1) begin
            // Non-memory result is written on the issue edge itself.
            if (bus.wb_rd != '0) begin
              we_d    = 1'b1;
              waddr_d = bus.wb_rd;
              wdata_d = operand;
            end
          end else if (misaligned(bus.ld_mode, bus.addr_lo)) begin
            ealign_d = 1'b1;
          end else begin
            state_d = S_WAIT_MEM;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT_MEM: begin
        // Valid takes priority over the timeout on the same edge.
        if (bus.mem_valid) begin
          state_d = S_IDLE;
          if (rd_q != '0) begin
            we_d    = 1'b1;
            waddr_d = rd_q;
            wdata_d = extract(mode_q, alo_q, bus.mem_data);
          end
        end else if (cnt == CNT_LAST) begin
          state_d = S_IDLE;
          etmo_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mode_q   <= '0;
      alo_q    <= '0;
      rd_q     <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      ealign_q <= 1'b0;
      etmo_q   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      mode_q   <= mode_d;
      alo_q    <= alo_d;
      rd_q     <= rd_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      ealign_q <= ealign_d;
      etmo_q   <= etmo_d;
    end
  end

  assign bus.reg_we      = we_q;
  assign bus.reg_waddr   = waddr_q;
  assign bus.reg_wdata   = wdata_q;
  assign bus.busy        = (state == S_WAIT_MEM);
  assign bus.err_align   = ealign_q;
  assign bus.err_timeout = etmo_q;

endmodule
